// File: rtl/key_display_if.sv
// Key/display bus: the scan-code byte stream in, the multiplexed 7-segment drive out.
interface key_display_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [7:0]            data;
   logic                  valid;
   logic [6:0]            segments;
   logic [NUM_DIGITS-1:0] anodes;
   logic [3:0]            count;

   modport master (output data, valid, input segments, anodes, count);
   modport slave  (input data, valid, output segments, anodes, count);
endinterface

// File: rtl/key_display_mux.sv
// PS/2 scan-code parser feeding a shift-in digit buffer on a scanned 7-segment display.
// Optional feature: define KEYDISP_BACKSPACE_EN to make scan code 0x66 erase the newest digit.
module key_display_mux #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_BITS = 16
) (
   input  logic          clk,
   input  logic          reset,
   key_display_if.slave  bus
);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0]  BLANK = 7'b111_1111;
   localparam logic [6:0]  DASH  = 7'b011_1111;

   typedef enum logic [1:0] {IDLE, EXT, BREAK} state_t;

   state_t                  state_q, state_n;
   logic                    push_c, bksp_c;
   logic [6:0]              pattern_c;
   logic [6:0]              digit_q [NUM_DIGITS];
   logic [6:0]              digit_n [NUM_DIGITS];
   logic [3:0]              count_q, count_n;
   logic [REFRESH_BITS-1:0] presc_q;
   logic [IDX_W-1:0]        idx_q, idx_n;

   // Parser state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_n;
   end

   // Parser next state: make codes push, release and extended prefixes swallow the next byte
   always_comb begin
      state_n = state_q;
      push_c  = 1'b0;
      bksp_c  = 1'b0;
      if (bus.valid) begin
         case (state_q)
            IDLE: begin
               if (bus.data == 8'hF0)      state_n = BREAK;
               else if (bus.data == 8'hE0) state_n = EXT;
`ifdef KEYDISP_BACKSPACE_EN
               else if (bus.data == 8'h66) bksp_c  = 1'b1;
`endif
               else                        push_c  = 1'b1;
            end
            EXT:     state_n = (bus.data == 8'hF0) ? BREAK : IDLE;
            BREAK:   state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Scan code to active-low gfe_dcba pattern
   always_comb begin
      case (bus.data)
         8'h1D:   pattern_c = 7'b100_0001;
         8'h1C:   pattern_c = 7'b000_1000;
         8'h2C:   pattern_c = 7'b000_0111;
         8'h24:   pattern_c = 7'b000_0110;
         8'h2D:   pattern_c = 7'b010_1111;
         8'h23:   pattern_c = 7'b010_0001;
         8'h2B:   pattern_c = 7'b000_1110;
         8'h34:   pattern_c = 7'b100_0010;
         8'h1B:   pattern_c = 7'b001_0010;
         8'h45:   pattern_c = 7'b100_0000;
         8'h16:   pattern_c = 7'b111_1001;
         8'h1E:   pattern_c = 7'b010_0100;
         8'h26:   pattern_c = 7'b011_0000;
         8'h25:   pattern_c = 7'b001_1001;
         8'h2E:   pattern_c = 7'b001_0010;
         8'h36:   pattern_c = 7'b000_0010;
         8'h3D:   pattern_c = 7'b111_1000;
         8'h3E:   pattern_c = 7'b000_0000;
         8'h46:   pattern_c = 7'b001_0000;
         default: pattern_c = DASH;
      endcase
   end

   // Next buffer contents and occupancy: push shifts toward the MSB digit, backspace the other way
   always_comb begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) digit_n[i] = digit_q[i];
      count_n = count_q;
      if (push_c) begin
         for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) digit_n[i] = digit_q[i-1];
         digit_n[0] = pattern_c;
         if (count_q < 4'(NUM_DIGITS)) count_n = count_q + 4'd1;
      end else if (bksp_c) begin
         for (int i = 0; i < int'(NUM_DIGITS) - 1; i++) digit_n[i] = digit_q[i+1];
         digit_n[NUM_DIGITS-1] = BLANK;
         if (count_q != 4'd0) count_n = count_q - 4'd1;
      end
   end

   // Scan index advances whenever the prescaler is about to wrap
   always_comb begin
      idx_n = idx_q;
      if (&presc_q) begin
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_n = '0;
         else                                 idx_n = idx_q + IDX_W'(1);
      end
   end

   // Buffer, refresh counters and registered display drive (drive follows the next-state values
   // so segments/anodes change in the same cycle as idx and the digits)
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= BLANK;
         count_q      <= 4'd0;
         presc_q      <= '0;
         idx_q        <= '0;
         bus.count    <= 4'd0;
         bus.segments <= BLANK;
         bus.anodes   <= ~NUM_DIGITS'(1);
      end else begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= digit_n[i];
         count_q      <= count_n;
         presc_q      <= presc_q + REFRESH_BITS'(1);
         idx_q        <= idx_n;
         bus.count    <= count_n;
         bus.segments <= digit_n[idx_n];
         bus.anodes   <= ~(NUM_DIGITS'(1) << idx_n);
      end
   end
endmodule

// File: tb/tb_key_display_mux.sv
// Directed bench for key_display_mux with NUM_DIGITS=4, REFRESH_BITS=2.
module tb_key_display_mux;
   localparam logic [6:0] BLANK = 7'b111_1111;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [6:0] cap [4];
   logic [3:0] exp_an;

   key_display_if #(.NUM_DIGITS(4)) bus ();

   key_display_mux #(.NUM_DIGITS(4), .REFRESH_BITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reset pulse spanning one rising edge; returns on the following falling edge
   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives one byte for one cycle; consecutive calls give back-to-back valid cycles
   task automatic send(input logic [7:0] b);
      bus.data  = b;
      bus.valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic stop_sending();
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      @(negedge clk);
   endtask

   // Observe one full refresh sweep and record the pattern shown on each digit
   task automatic capture();
      for (int i = 0; i < 4; i++) cap[i] = 7'bxxx_xxxx;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 4; i++)
            if (bus.anodes[i] == 1'b0) cap[i] = bus.segments;
         @(negedge clk);
      end
   endtask

   task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0, input logic [3:0] cnt);
      capture();
      check({tag, "_d0"}, 32'(cap[0]), 32'(d0));
      check({tag, "_d1"}, 32'(cap[1]), 32'(d1));
      check({tag, "_d2"}, 32'(cap[2]), 32'(d2));
      check({tag, "_d3"}, 32'(cap[3]), 32'(d3));
      check({tag, "_count"}, 32'(bus.count), 32'(cnt));
   endtask

   initial begin
      reset     = 1'b0;
      bus.valid = 1'b0;
      bus.data  = 8'h00;

      // Idle refresh sweep after reset: each anode low for 4 cycles in turn
      do_reset();
      for (int k = 0; k < 16; k++) begin
         case (k / 4)
            0:       exp_an = 4'b1110;
            1:       exp_an = 4'b1101;
            2:       exp_an = 4'b1011;
            default: exp_an = 4'b0111;
         endcase
         check($sformatf("idle_anodes_%0d", k), 32'(bus.anodes), 32'(exp_an));
         check($sformatf("idle_seg_%0d", k), 32'(bus.segments), 32'(BLANK));
         check($sformatf("idle_count_%0d", k), 32'(bus.count), 32'd0);
         @(negedge clk);
      end

      // Press and release of A: only the make code lands
      do_reset();
      send(8'h1C); send(8'hF0); send(8'h1C); stop_sending();
      check_digits("press_release", BLANK, BLANK, BLANK, 7'b000_1000, 4'd1);

      // Five digits into a four-digit buffer: oldest dropped, count saturates
      do_reset();
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E); stop_sending();
      check_digits("overflow", 7'b010_0100, 7'b011_0000, 7'b001_1001, 7'b001_0010, 4'd4);

      // Extended make, extended break, then E
      do_reset();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h24);
      stop_sending();
      check_digits("extended", BLANK, BLANK, BLANK, 7'b000_0110, 4'd1);

      // Reset in BREAK with a byte presented in the reset cycle; the next byte is a make code
      do_reset();
      send(8'hF0);
      bus.data  = 8'h24;
      bus.valid = 1'b1;
      reset     = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      bus.valid = 1'b0;
      check("reset_wins_count", 32'(bus.count), 32'd0);
      check("reset_wins_seg", 32'(bus.segments), 32'(BLANK));
      send(8'h24); stop_sending();
      check_digits("reset_break", BLANK, BLANK, BLANK, 7'b000_0110, 4'd1);

      // Scan code 0x66
      do_reset();
      send(8'h24); send(8'h2D); send(8'h66); stop_sending();
`ifdef KEYDISP_BACKSPACE_EN
      check_digits("bksp_one", BLANK, BLANK, BLANK, 7'b000_0110, 4'd1);
      send(8'h66); send(8'h66); stop_sending();
      check_digits("bksp_empty", BLANK, BLANK, BLANK, BLANK, 4'd0);
`else
      check_digits("code66_dash", BLANK, 7'b000_0110, 7'b010_1111, 7'b011_1111, 4'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the sequence above ever stalls
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
